// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: slice record layout, chunk sizing and config checks
// shared by pipelined_adder and adder_slice.
package pipelined_adder_pkg;

  // Slice record: {b, a, sum, carry, valid}, each operand/sum WIDTH bits.
  localparam int V_OFF = 0;
  localparam int C_OFF = 1;
  localparam int S_OFF = 2;

  function automatic int a_off(input int w);
    return S_OFF + w;
  endfunction

  function automatic int b_off(input int w);
    return S_OFF + 2 * w;
  endfunction

  function automatic int rec_w(input int w);
    return S_OFF + 3 * w;
  endfunction

  function automatic int chunk_w(input int w, input int s);
    if (s < 1) return w;
    return w / s;
  endfunction

  function automatic bit cfg_ok(input int w, input int s);
    if (s < 1 || w < 1) return 1'b0;
    return (w % s) == 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: one CHUNK-bit carry-chain slice plus its pipeline register.
// Ports: clk, rst_n, adv (load enable), prev (upstream record), rec (this slice).
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic [rec_w(WIDTH)-1:0] prev,
  output logic [rec_w(WIDTH)-1:0] rec
);

  localparam int RW = rec_w(WIDTH);
  localparam int AO = a_off(WIDTH) + IDX * CHUNK;
  localparam int BO = b_off(WIDTH) + IDX * CHUNK;
  localparam int SO = S_OFF + IDX * CHUNK;

  logic [CHUNK-1:0] a;
  logic [CHUNK-1:0] b;
  logic [CHUNK-1:0] s;
  logic             c;
  logic [RW-1:0]    nxt;

  // Bubbles are added too; their valid bit of 0 makes the sum irrelevant.
  always_comb begin
    a      = prev[AO +: CHUNK];
    b      = prev[BO +: CHUNK];
    {c, s} = {1'b0, a} + {1'b0, b}
           + {{CHUNK{1'b0}}, prev[C_OFF]};
    nxt    = prev;
    nxt[SO +: CHUNK] = s;
    nxt[C_OFF]       = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec <= '0;
    end else if (adv) begin
      rec <= nxt;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit elastic adder in STAGES registered slices.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_cin,
// out_valid/out_ready/out_sum/out_cout. Define PIPELINED_ADDER_SUB_EN
// to add in_sub (A - B as A + ~B + 1, out_cout=1 means no borrow).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int RW    = rec_w(WIDTH);
  localparam int NS    = (STAGES < 1) ? 1 : STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES >= 1");
  end

  logic [RW-1:0]          head;
  logic [NS-1:0][RW-1:0]  pipe;
  logic [NS-1:0]          v;
  logic [NS-1:0]          adv;
  logic [WIDTH-1:0]       b_eff;
  logic                   c_eff;
  logic                   unused_ops;

  always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
    b_eff = in_sub ? ~in_b : in_b;
    c_eff = in_sub ? 1'b1 : in_cin;
`else
    b_eff = in_b;
    c_eff = in_cin;
`endif
  end

  always_comb begin
    head = '0;
    head[V_OFF] = in_valid;
    head[C_OFF] = c_eff;
    head[a_off(WIDTH) +: WIDTH] = in_a;
    head[b_off(WIDTH) +: WIDTH] = b_eff;
  end

  // A slice may load when it is empty or everything after it moves.
  always_comb begin
    logic run;
    run = out_ready;
    adv = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      run    = run | ~v[k];
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_slice
    assign v[k] = pipe[k][V_OFF];
    if (k == 0) begin : g_first
      adder_slice #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDX   (k)
      ) u_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv[k]),
        .prev  (head),
        .rec   (pipe[k])
      );
    end else begin : g_rest
      adder_slice #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDX   (k)
      ) u_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv[k]),
        .prev  (pipe[k-1]),
        .rec   (pipe[k])
      );
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = pipe[NS-1][V_OFF];
  assign out_cout  = pipe[NS-1][C_OFF];
  assign out_sum   = pipe[NS-1][S_OFF +: WIDTH];

  // Operand fields of the last slice are fully consumed.
  assign unused_ops = ^pipe[NS-1][RW-1:a_off(WIDTH)];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table, stall/reset sequences (16/4)
// and a random scoreboard run on a 32/8 instance.
module tb_pipelined_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin;
  logic [15:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout;
`ifdef PIPELINED_ADDER_SUB_EN
  logic        in_sub, sub32;
`endif

  logic        v32, rdy32, c32, ov32, r32, cout32;
  logic [31:0] a32, b32, sum32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v32),
    .in_ready  (rdy32),
    .in_a      (a32),
    .in_b      (b32),
    .in_cin    (c32),
`ifdef PIPELINED_ADDER_SUB_EN
    .in_sub    (sub32),
`endif
    .out_valid (ov32),
    .out_ready (r32),
    .out_sum   (sum32),
    .out_cout  (cout32)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub,
                              input logic [15:0] sum, input logic cout);
    vec_t t;
    t.a = a; t.b = b; t.cin = cin; t.sub = sub;
    t.sum = sum; t.cout = cout;
    return t;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    in_a = a; in_b = b; in_cin = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    in_sub = sub;
`else
    if (sub) $display("sub vector skipped in add-only build");
`endif
  endtask

  task automatic run_one(input vec_t t, input string tag);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    drive(t.a, t.b, t.cin, t.sub);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (out_valid || n > 10) break;
      @(posedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, out_sum, t.sum);
    chk({tag, "_cout"}, out_cout, t.cout);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_single_pulse"}, out_valid, 0);
  endtask

  function automatic logic [16:0] op_exp(input int i);
    logic [15:0] a, b;
    a = 16'hF000 + 16'(i * 16'h0123);
    b = 16'h1000 + 16'(i);
    return {1'b0, a} + {1'b0, b} + 17'(i & 1);
  endfunction

  task automatic stall_seq();
    logic [16:0] q[$];
    logic [16:0] hold;
    logic        hold_v, saw_full;
    int          sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    hold_v = 0; saw_full = 0; hold = '0;
    while (rcvd < 10 && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 7);
      in_valid  = (sent < 10);
      drive(16'hF000 + 16'(sent * 16'h0123), 16'h1000 + 16'(sent),
            1'(sent & 1), 1'b0);
      @(negedge clk);
      if (in_valid && !in_ready && !saw_full) begin
        saw_full = 1;
        chk("stall_depth", sent - rcvd, 4);
      end
      if (out_valid && !out_ready) begin
        if (hold_v) chk("hold_stable", {out_cout, out_sum}, hold);
        hold_v = 1;
        hold   = {out_cout, out_sum};
      end else begin
        hold_v = 0;
      end
      if (in_valid && in_ready) begin
        q.push_back(op_exp(sent));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_spurious", 1, 0);
        end else begin
          chk("stream_sum", {out_cout, out_sum}, q.pop_front());
        end
        rcvd++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_seen", saw_full, 1);
    chk("stream_sent", sent, 10);
    chk("stream_rcvd", rcvd, 10);
    @(posedge clk);
    @(negedge clk);
    chk("stream_no_dup", out_valid, 0);
  endtask

  task automatic reset_seq();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      drive(16'(i + 16'h0101), 16'h0202, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sum", out_sum, 0);
    chk("rst_mid_cout", out_cout, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_stale", seen, 0);
    run_one(mk(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0), "post_rst");
  endtask

  task automatic random32();
    logic [32:0] q[$];
    logic        pend;
    int          sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; pend = 0;
    while (rcvd < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      if (!pend && sent < 10000 && $urandom_range(0, 9) < 7) begin
        pend = 1;
        a32  = $urandom;
        b32  = $urandom;
        c32  = 1'($urandom_range(0, 1));
      end
      v32 = pend;
      r32 = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (v32 && rdy32) begin
        q.push_back({1'b0, a32} + {1'b0, b32} + 33'(c32));
        sent++;
        pend = 0;
      end
      if (ov32 && r32) begin
        if (q.size() == 0) begin
          chk("rand32_spurious", 1, 0);
        end else begin
          chk("rand32_sum", {cout32, sum32}, q.pop_front());
        end
        rcvd++;
      end
      cyc++;
    end
    v32 = 1'b0;
    chk("rand32_count", rcvd, 10000);
  endtask

  initial begin
    vec_t vecs[$];
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    v32 = 1'b0; r32 = 1'b1; a32 = '0; b32 = '0; c32 = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
    sub32 = 1'b0;
`endif

    vecs.push_back(mk(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0));
    vecs.push_back(mk(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1));
    vecs.push_back(mk(16'h1234, 16'h4321, 0, 0, 16'h5555, 0));
    vecs.push_back(mk(16'h8000, 16'h8000, 0, 0, 16'h0000, 1));
    vecs.push_back(mk(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0));
    vecs.push_back(mk(16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'hABCD, 16'h1111, 1, 0, 16'hBCDF, 0));
`ifdef PIPELINED_ADDER_SUB_EN
    vecs.push_back(mk(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0));
    vecs.push_back(mk(16'h0007, 16'h0005, 0, 1, 16'h0002, 1));
    vecs.push_back(mk(16'h0007, 16'h0005, 1, 1, 16'h0002, 1));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_cout", out_cout, 0);
    chk("reset_in_ready32", rdy32, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    stall_seq();
    reset_seq();
    random32();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
